// File: rtl/dafir_pkg.sv
// Shared DA-FIR definitions: sequencer state encoding and default DA word width.
package dafir_pkg;

    localparam int DA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seri_fa_bit.sv
// One-bit combinational full-adder slice for the bit-serial adder datapath.
module seri_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/seri_add_ctrl.sv
// Bit-serial add sequencer: streams operands LSB-first through one full-adder slice.
// Optional macro SERI_ADD_SUB_EN adds a 'sub' port for modulo subtraction.
module seri_add_ctrl
    import dafir_pkg::*;
#(
    parameter  int WIDTH = DA_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             RstN,
`ifdef SERI_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [WIDTH-1:0] res_sr_reg, res_sr_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;

    logic             fa_b, fa_s, fa_co, carry_init;
    logic [WIDTH-1:0] res_shifted;

`ifdef SERI_ADD_SUB_EN
    logic sub_reg, sub_next;
    // Subtraction is a + ~b + 1: invert each b bit and seed the carry with 1.
    assign fa_b       = b_sr_reg[0] ^ sub_reg;
    assign carry_init = sub;
`else
    assign fa_b       = b_sr_reg[0];
    assign carry_init = 1'b0;
`endif

    seri_fa_bit u_fa (
        .a  (a_sr_reg[0]),
        .b  (fa_b),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    assign res_shifted = {fa_s, res_sr_reg[WIDTH-1:1]};

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a_sr_next   = a_sr_reg;
        b_sr_next   = b_sr_reg;
        res_sr_next = res_sr_reg;
        sum_next    = sum_reg;
        carry_next  = carry_reg;
        cout_next   = cout_reg;
`ifdef SERI_ADD_SUB_EN
        sub_next    = sub_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    a_sr_next   = a_in;
                    b_sr_next   = b_in;
                    carry_next  = carry_init;
                    cnt_next    = '0;
                    res_sr_next = '0;
`ifdef SERI_ADD_SUB_EN
                    sub_next    = sub;
`endif
                    state_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                carry_next  = fa_co;
                res_sr_next = res_shifted;
                a_sr_next   = a_sr_reg >> 1;
                b_sr_next   = b_sr_reg >> 1;
                cnt_next    = cnt_reg + CNT_W'(1);
                // Last slice: publish the completed word together with its carry-out.
                if (cnt_reg == CNT_LAST) begin
                    sum_next   = res_shifted;
                    cout_next  = fa_co;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
`ifdef SERI_ADD_SUB_EN
            sub_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a_sr_reg   <= a_sr_next;
            b_sr_reg   <= b_sr_next;
            res_sr_reg <= res_sr_next;
            sum_reg    <= sum_next;
            carry_reg  <= carry_next;
            cout_reg   <= cout_next;
`ifdef SERI_ADD_SUB_EN
            sub_reg    <= sub_next;
`endif
        end
    end

    assign ready   = (state_reg == ST_IDLE);
    assign busy    = (state_reg == ST_SHIFT);
    assign done    = (state_reg == ST_DONE);
    assign sum_out = sum_reg;
    assign cout    = cout_reg;

endmodule

// File: tb/tb_seri_add_ctrl.sv
// Directed bench for seri_add_ctrl at WIDTH=8: vector table plus multi-cycle corner sequences.
module tb_seri_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         RstN;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         ready, busy, done, cout;
    logic [W-1:0] sum_out;
`ifdef SERI_ADD_SUB_EN
    logic         sub;
`endif

    int total = 0;
    int bad   = 0;

    seri_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .RstN    (RstN),
`ifdef SERI_ADD_SUB_EN
        .sub     (sub),
`endif
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         co;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_busy"},  32'(busy),  32'd0);
        check({tag, "_done"},  32'(done),  32'd0);
        check({tag, "_sum"},   32'(sum_out), 32'd0);
        check({tag, "_cout"},  32'(cout),  32'd0);
    endtask

    // One full add: accept, scramble inputs, wait for done, check latency and result.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] es, input logic ec);
        int lat;
        check("idle_ready", 32'(ready), 32'd1);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        check("accept_ready", 32'(ready), 32'd0);
        check("accept_busy",  32'(busy),  32'd1);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        check("latency", 32'(lat), 32'(W));
        check("sum",  32'(sum_out), 32'(es));
        check("cout", 32'(cout),    32'(ec));
        $display("add a=%h b=%h -> sum=%h cout=%b latency=%0d", a, b, sum_out, cout, lat);
        tick();
        check("done_one_cycle", 32'(done),  32'd0);
        check("back_to_ready",  32'(ready), 32'd1);
        check("sum_hold",       32'(sum_out), 32'(es));
    endtask

    initial begin
        int dcount;
        int cyc, prev_done, ready_cnt, pulses;

        vecs[0] = '{8'h01, 8'h01, 8'h02, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'h0F, 8'h0F, 8'h1E, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
        vecs[6] = '{8'h7F, 8'h7F, 8'hFE, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};

        RstN  = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef SERI_ADD_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        check_reset_outputs("reset");
        RstN = 1'b1;
        tick();
        check("idle_no_start_ready", 32'(ready), 32'd1);

        for (int i = 0; i < 8; i++)
            run_add(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].co);

        // start pulsed during SHIFT must be ignored; exactly one done.
        start = 1'b1; a_in = 8'h0F; b_in = 8'h0F;
        tick();
        start = 1'b0;
        dcount = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h55; end
            if (n == 4) start = 1'b0;
            tick();
            if (done) begin
                dcount++;
                check("ignore_sum",  32'(sum_out), 32'h1E);
                check("ignore_cout", 32'(cout),    32'd0);
            end
        end
        check("ignore_done_count", 32'(dcount), 32'd1);
        $display("add a=0f b=0f with stray start -> sum=%h done_pulses=%0d", sum_out, dcount);

        // Reset asserted after the 4th SHIFT edge aborts the operation.
        start = 1'b1; a_in = 8'h80; b_in = 8'h80;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        check("pre_abort_busy", 32'(busy), 32'd1);
        RstN = 1'b0;
        #1;
        check_reset_outputs("abort");
        #2;
        RstN = 1'b1;
        dcount = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        $display("add a=80 b=80 aborted by reset -> done_pulses=%0d", dcount);
        run_add(8'h03, 8'h04, 8'h07, 1'b0);

        // Continuous start: one done every W+2 cycles with one ready cycle between.
        start = 1'b1; a_in = 8'h10; b_in = 8'h20;
        cyc = 0; prev_done = -1; ready_cnt = 0; pulses = 0;
        for (int n = 0; n < 60 && pulses < 3; n++) begin
            tick();
            cyc++;
            if (ready) ready_cnt++;
            if (done) begin
                check("stream_sum",  32'(sum_out), 32'h30);
                check("stream_cout", 32'(cout),    32'd0);
                if (prev_done >= 0) begin
                    check("stream_period", 32'(cyc - prev_done), 32'(W + 2));
                    check("stream_ready_cycles", 32'(ready_cnt), 32'd1);
                end
                $display("add a=10 b=20 streamed -> sum=%h cycle=%0d", sum_out, cyc);
                prev_done = cyc;
                ready_cnt = 0;
                pulses++;
            end
        end
        check("stream_pulses", 32'(pulses), 32'd3);
        start = 1'b0;
        for (int n = 0; n < 12; n++) tick();

`ifdef SERI_ADD_SUB_EN
        sub = 1'b1;
        run_add(8'h05, 8'h07, 8'hFE, 1'b0);
        run_add(8'h07, 8'h05, 8'h02, 1'b1);
        sub = 1'b0;
        run_add(8'h07, 8'h05, 8'h0C, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
